out_pkg_dispatch: RTL and testbench
===================================

Name: out_pkg_dispatch

Overview:
- Upstream feeder of the dual-port output memory. Buffers result packages (addr + 512-bit data) from the Winograd output-transform stage in a small FIFO.
- Each cycle it dispatches up to two packages onto lane 1 and lane 2 (addr_x, data_x, package_x_valid) of the memory.
- It serialises same-address pairs, pauses while the memory is out of load/store mode, and reports layer-end drain completion.

Parameters:
- ADDR_W, 8, package address width
- DATA_W, 512, package data width
- FIFO_DEPTH, 4, buffer entries; power of two, >= 2
- CNT_W, 16, width of the issued-package counter

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream package valid
- in_ready  out  1  buffer can accept
- in_addr  in  ADDR_W  package address
- in_data  in  DATA_W  package data
- mem_stall  in  1  memory not in load/store mode; suppress dispatch
- flush  in  1  end of layer; drain buffer
- busy  out  1  state is RUN or DRAIN
- done  out  1  one-cycle pulse when drain completes
- pkg_count  out  CNT_W  packages issued since the last IDLE->RUN transition
- addr_1_out  out  ADDR_W  lane 1 address
- data_1_out  out  DATA_W  lane 1 data
- package_1_valid_out  out  1  lane 1 valid
- addr_2_out  out  ADDR_W  lane 2 address
- data_2_out  out  DATA_W  lane 2 data
- package_2_valid_out  out  1  lane 2 valid

Behaviour:
- Reset: all outputs are 0 except in_ready = 1. FIFO is emptied, state = IDLE.
- Reset mid-operation discards buffered entries and clears the outputs immediately (asynchronously).
- FSM:
  - IDLE -> RUN on an accepted beat; pkg_count clears on this transition.
  - IDLE -> DONE on flush.
  - RUN -> DRAIN on flush. A beat presented in the same cycle is still accepted if in_ready.
  - DRAIN -> DONE when the FIFO is empty and no package is issued that cycle.
  - DONE -> IDLE after 1 cycle; done = 1 only while in DONE.
- in_ready = (count < FIFO_DEPTH) and state != DRAIN/DONE. It uses registered count and is not pop-aware.
- Push and pop in the same cycle are legal.
- Dispatch (RUN or DRAIN, mem_stall = 0), evaluated on the registered FIFO heads h0 (oldest) and h1:
  - count >= 2 and h0.addr != h1.addr: h0 -> lane 1, h1 -> lane 2; pop 2.
  - count >= 2 and h0.addr == h1.addr: h0 -> lane 1 only; pop 1.
  - count == 1: h0 -> lane 1 only; pop 1.
  - count == 0, or mem_stall = 1, or state IDLE/DONE: no pop; both valids 0.
- Lane 2 is never valid without lane 1. Lane 1 always carries the older package.
- Outputs are registered: a package accepted in cycle k appears on a lane at the earliest in cycle k+1.
- While a valid is 0, its addr/data hold their last values.
- pkg_count increments by the number of valids issued. It saturates at all-ones and holds through DONE/IDLE.
- No cross-cycle address hazard checking; the memory orders consecutive cycles.
- mem_stall asserted mid-stream freezes dispatch without losing entries. Accepts continue until full.

Decomposition:
- Package winocnn_out_pkg: ADDR_W/DATA_W constants, typedef out_pkg_t {addr, data}, enum disp_state_t {IDLE, RUN, DRAIN, DONE}.
- One sub-module, out_pkg_fifo: a circular FIFO with a single push and pop-0/1/2 per cycle. It exposes head0, head1 and count.
- The top holds the FSM, the pairing logic, the output registers and the counter.

Test Plan:
- Reset: assert reset mid-cycle -> all valids/addr/data/pkg_count 0, in_ready = 1, busy = 0, done = 0, immediately.
- Single beat: accept addr 0x05, data 0x1 in cycle k (mem_stall = 0) -> cycle k+1: package_1_valid_out = 1, addr_1_out = 0x05, package_2_valid_out = 0; pkg_count = 1.
- Pairing:
  - Stimulus: mem_stall = 1; push 0x05, 0x0A, 0x01, 0x09. in_ready drops after the 4th beat. Then release mem_stall.
  - Required response: first cycle lanes carry (0x05, 0x0A), next cycle (0x01, 0x09); pkg_count = 4; FIFO empty.
- Same-address: mem_stall = 1; push 0x05, 0x05, 0x0B; release -> cycle 1: lane 1 = 0x05 only; cycle 2: lanes (0x05, 0x0B).
- Drain:
  - Stimulus: 3 entries buffered under stall, then flush, then release.
  - Required response: busy = 1 and in_ready = 0 during DRAIN; done pulses for exactly 1 cycle after the last package; state returns to IDLE.
- Reset in DRAIN with 2 entries buffered -> outputs clear immediately; no packages after release; a following flush in IDLE gives a done pulse with pkg_count = 0.

Source files
------------

// File: rtl/winocnn_out_pkg.sv
// winocnn_out_pkg: shared widths, package record and dispatcher state encoding.
package winocnn_out_pkg;
  localparam int OUT_ADDR_W = 8;
  localparam int OUT_DATA_W = 512;
  typedef struct packed {
    logic [OUT_ADDR_W-1:0] addr;
    logic [OUT_DATA_W-1:0] data;
  } out_pkg_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} disp_state_t;
endpackage

// File: rtl/out_pkg_fifo.sv
// out_pkg_fifo: circular buffer with one push and a pop of 0, 1 or 2 entries per cycle.
module out_pkg_fifo
  import winocnn_out_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  out_pkg_t      push_pkg,
  input  logic [1:0]    pop,
  output out_pkg_t      head0,
  output out_pkg_t      head1,
  output logic [PW:0]   count
);
  out_pkg_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign head0 = mem[rd];
  assign head1 = mem[rd + PW'(1)];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      rd <= rd + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  // storage needs no reset; only entries below count are ever read out
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_pkg;
endmodule

// File: rtl/out_pkg_dispatch.sv
// out_pkg_dispatch: buffers output-transform packages and issues up to two per cycle
// onto the dual-port output memory, splitting same-address pairs and draining at layer end.
module out_pkg_dispatch
  import winocnn_out_pkg::*;
#(
  parameter int ADDR_W = OUT_ADDR_W,
  parameter int DATA_W = OUT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkg_count,
  output logic [ADDR_W-1:0] addr_1_out,
  output logic [DATA_W-1:0] data_1_out,
  output logic              package_1_valid_out,
  output logic [ADDR_W-1:0] addr_2_out,
  output logic [DATA_W-1:0] data_2_out,
  output logic              package_2_valid_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  disp_state_t state;
  out_pkg_t in_pkg, h0, h1;
  logic [PW:0] count;
  logic [1:0] pop;
  logic accept, active, issue1, issue2;
  logic [CNT_W:0] cnt_sum;
  assign in_pkg = '{addr: in_addr, data: in_data};
  assign in_ready = (count < (PW+1)'(FIFO_DEPTH)) && (state == IDLE || state == RUN);
  assign accept = in_valid && in_ready;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign active = busy && !mem_stall;
  assign issue1 = active && count != '0;
  assign issue2 = issue1 && count >= (PW+1)'(2) && h0.addr != h1.addr;
  assign pop = {issue2, issue1 && !issue2};
  assign cnt_sum = {1'b0, pkg_count} + (CNT_W+1)'(issue1) + (CNT_W+1)'(issue2);

  out_pkg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(accept), .push_pkg(in_pkg),
    .pop(pop), .head0(h0), .head1(h1), .count(count)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pkg_count <= '0;
      addr_1_out <= '0;
      data_1_out <= '0;
      package_1_valid_out <= 1'b0;
      addr_2_out <= '0;
      data_2_out <= '0;
      package_2_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE:  state <= accept ? (flush ? DRAIN : RUN) : (flush ? DONE : IDLE);
        RUN:   state <= flush ? DRAIN : RUN;
        DRAIN: state <= count == '0 ? DONE : DRAIN;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
      // nothing is issued in IDLE, so clearing on the start beat loses no count
      pkg_count <= (state == IDLE && accept) ? '0 : cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      package_1_valid_out <= issue1;
      package_2_valid_out <= issue2;
      if (issue1) begin
        addr_1_out <= h0.addr;
        data_1_out <= h0.data;
      end
      if (issue2) begin
        addr_2_out <= h1.addr;
        data_2_out <= h1.data;
      end
    end
endmodule

// File: tb/tb_out_pkg_dispatch.sv
// tb_out_pkg_dispatch: directed scenario checks for the output package dispatcher.
module tb_out_pkg_dispatch;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, mem_stall = 1'b0, flush = 1'b0, busy, done;
  logic [7:0] in_addr = '0, addr_1_out, addr_2_out;
  logic [511:0] in_data = '0, data_1_out, data_2_out;
  logic [15:0] pkg_count;
  logic package_1_valid_out, package_2_valid_out;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  out_pkg_dispatch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .mem_stall(mem_stall), .flush(flush),
    .busy(busy), .done(done), .pkg_count(pkg_count),
    .addr_1_out(addr_1_out), .data_1_out(data_1_out), .package_1_valid_out(package_1_valid_out),
    .addr_2_out(addr_2_out), .data_2_out(data_2_out), .package_2_valid_out(package_2_valid_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a);
    in_valid = 1'b1;
    in_addr = a;
    in_data = {64{a}};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic check_cleared(input string tag);
    total++; if (package_1_valid_out !== 1'b0 || package_2_valid_out !== 1'b0) $display("FAIL %s valids got %b%b want 00", tag, package_1_valid_out, package_2_valid_out); else pass++;
    total++; if (addr_1_out !== 8'h00 || addr_2_out !== 8'h00) $display("FAIL %s addrs got %h/%h want 00/00", tag, addr_1_out, addr_2_out); else pass++;
    total++; if (data_1_out !== '0 || data_2_out !== '0) $display("FAIL %s data got nonzero want 0", tag); else pass++;
    total++; if (pkg_count !== 16'd0) $display("FAIL %s pkg_count got %0d want 0", tag, pkg_count); else pass++;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL %s ready/busy/done got %b%b%b want 100", tag, in_ready, busy, done); else pass++;
  endtask

  task automatic test_reset();
    tick();
    check_cleared("por");
    reset = 1'b0;
    tick();
    check_cleared("post_por");
  endtask

  task automatic test_single_beat();
    do_reset();
    push(8'h05);
    total++; if (package_1_valid_out !== 1'b0) $display("FAIL single_early got %b want 0", package_1_valid_out); else pass++;
    tick();
    total++; if (package_1_valid_out !== 1'b1 || addr_1_out !== 8'h05) $display("FAIL single_lane1 got v=%b a=%h want v=1 a=05", package_1_valid_out, addr_1_out); else pass++;
    total++; if (data_1_out !== {64{8'h05}}) $display("FAIL single_data got %h want %h", data_1_out[63:0], {8{8'h05}}); else pass++;
    total++; if (package_2_valid_out !== 1'b0) $display("FAIL single_lane2 got %b want 0", package_2_valid_out); else pass++;
    total++; if (pkg_count !== 16'd1 || busy !== 1'b1) $display("FAIL single_count got %0d busy=%b want 1 busy=1", pkg_count, busy); else pass++;
    tick();
    total++; if (package_1_valid_out !== 1'b0 || addr_1_out !== 8'h05) $display("FAIL single_hold got v=%b a=%h want v=0 a=05", package_1_valid_out, addr_1_out); else pass++;
    #2 reset = 1'b1;
    #1 check_cleared("async_reset");
    #1 reset = 1'b0;
  endtask

  task automatic test_pairing();
    do_reset();
    mem_stall = 1'b1;
    push(8'h05);
    push(8'h0A);
    push(8'h01);
    total++; if (in_ready !== 1'b1) $display("FAIL pair_ready3 got %b want 1", in_ready); else pass++;
    push(8'h09);
    total++; if (in_ready !== 1'b0 || package_1_valid_out !== 1'b0) $display("FAIL pair_full got rdy=%b v1=%b want 0 0", in_ready, package_1_valid_out); else pass++;
    mem_stall = 1'b0;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b11 || addr_1_out !== 8'h05 || addr_2_out !== 8'h0A) $display("FAIL pair_first got v=%b%b %h,%h want 11 05,0a", package_1_valid_out, package_2_valid_out, addr_1_out, addr_2_out); else pass++;
    total++; if (data_2_out !== {64{8'h0A}}) $display("FAIL pair_data2 got %h want %h", data_2_out[63:0], {8{8'h0A}}); else pass++;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b11 || addr_1_out !== 8'h01 || addr_2_out !== 8'h09) $display("FAIL pair_second got v=%b%b %h,%h want 11 01,09", package_1_valid_out, package_2_valid_out, addr_1_out, addr_2_out); else pass++;
    total++; if (pkg_count !== 16'd4 || in_ready !== 1'b1) $display("FAIL pair_count got %0d rdy=%b want 4 1", pkg_count, in_ready); else pass++;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b00 || pkg_count !== 16'd4) $display("FAIL pair_empty got v=%b%b cnt=%0d want 00 4", package_1_valid_out, package_2_valid_out, pkg_count); else pass++;
  endtask

  task automatic test_same_addr();
    do_reset();
    mem_stall = 1'b1;
    push(8'h05);
    push(8'h05);
    push(8'h0B);
    mem_stall = 1'b0;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b10 || addr_1_out !== 8'h05) $display("FAIL same_first got v=%b%b a1=%h want 10 05", package_1_valid_out, package_2_valid_out, addr_1_out); else pass++;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b11 || addr_1_out !== 8'h05 || addr_2_out !== 8'h0B) $display("FAIL same_second got v=%b%b %h,%h want 11 05,0b", package_1_valid_out, package_2_valid_out, addr_1_out, addr_2_out); else pass++;
    total++; if (pkg_count !== 16'd3) $display("FAIL same_count got %0d want 3", pkg_count); else pass++;
  endtask

  task automatic test_drain();
    do_reset();
    mem_stall = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) $display("FAIL drain_state got busy=%b rdy=%b done=%b want 1 0 0", busy, in_ready, done); else pass++;
    mem_stall = 1'b0;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b11 || addr_1_out !== 8'h01 || addr_2_out !== 8'h02) $display("FAIL drain_pair got v=%b%b %h,%h want 11 01,02", package_1_valid_out, package_2_valid_out, addr_1_out, addr_2_out); else pass++;
    tick();
    total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b10 || addr_1_out !== 8'h03 || done !== 1'b0) $display("FAIL drain_last got v=%b%b a1=%h done=%b want 10 03 0", package_1_valid_out, package_2_valid_out, addr_1_out, done); else pass++;
    tick();
    total++; if (done !== 1'b1 || package_1_valid_out !== 1'b0 || busy !== 1'b0) $display("FAIL drain_done got done=%b v1=%b busy=%b want 1 0 0", done, package_1_valid_out, busy); else pass++;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL drain_idle got done=%b busy=%b rdy=%b want 0 0 1", done, busy, in_ready); else pass++;
    total++; if (pkg_count !== 16'd3) $display("FAIL drain_count got %0d want 3", pkg_count); else pass++;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    mem_stall = 1'b1;
    push(8'h11);
    push(8'h22);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL rdrain_pre got busy=%b rdy=%b want 1 0", busy, in_ready); else pass++;
    #2 reset = 1'b1;
    #1 total++; if (busy !== 1'b0 || in_ready !== 1'b1 || pkg_count !== 16'd0) $display("FAIL rdrain_async got busy=%b rdy=%b cnt=%0d want 0 1 0", busy, in_ready, pkg_count); else pass++;
    #1 reset = 1'b0;
    mem_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({package_1_valid_out, package_2_valid_out} !== 2'b00) $display("FAIL rdrain_quiet%0d got v=%b%b want 00", i, package_1_valid_out, package_2_valid_out); else pass++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (done !== 1'b1 || pkg_count !== 16'd0) $display("FAIL rdrain_done got done=%b cnt=%0d want 1 0", done, pkg_count); else pass++;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rdrain_idle got done=%b busy=%b want 0 0", done, busy); else pass++;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_pairing();
    test_same_addr();
    test_drain();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
